// File: rtl/t05_flv_pkg.sv
// Shared definitions for the Huffman least-two finder: node encoding,
// controller handshake codes and scan FSM states.
package t05_flv_pkg;

    localparam logic [8:0] NULL_NODE = 9'h180;

    localparam logic [3:0] FIN_NONE = 4'b0000;
    localparam logic [3:0] FIN_DONE = 4'b0010;
    localparam logic [3:0] FIN_ERR  = 4'b1000;

    localparam logic [3:0] EN_FLV = 4'b0010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHAR_REQ,
        S_CHAR_WAIT,
        S_SUM_REQ,
        S_SUM_WAIT,
        S_RESULT,
        S_DONE,
        S_ERR
    } flv_state_t;

    function automatic logic is_leaf(input logic [8:0] node);
        return !node[8];
    endfunction

    function automatic logic is_sum(input logic [8:0] node);
        return node[8] && !node[7];
    endfunction

    function automatic logic is_null(input logic [8:0] node);
        return node == NULL_NODE;
    endfunction

endpackage

// File: rtl/t05_least_two.sv
// Running minimum tracker: keeps the two smallest candidates seen since the
// last clear, earlier candidates winning ties.
module t05_least_two #(
    parameter int FREQ_W = 46
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              cand_vld,
    input  logic [8:0]        cand_node,
    input  logic [FREQ_W-1:0] cand_freq,
    output logic [8:0]        best_node,
    output logic [FREQ_W-1:0] best_freq,
    output logic [8:0]        second_node,
    output logic [FREQ_W-1:0] second_freq
);
    import t05_flv_pkg::*;

    // Empty slots hold an all-ones frequency so any real candidate beats them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_node   <= NULL_NODE;
            best_freq   <= '1;
            second_node <= NULL_NODE;
            second_freq <= '1;
        end else if (clear) begin
            best_node   <= NULL_NODE;
            best_freq   <= '1;
            second_node <= NULL_NODE;
            second_freq <= '1;
        end else if (cand_vld) begin
            if (cand_freq < best_freq) begin
                second_node <= best_node;
                second_freq <= best_freq;
                best_node   <= cand_node;
                best_freq   <= cand_freq;
            end else if (cand_freq < second_freq) begin
                second_node <= cand_node;
                second_freq <= cand_freq;
            end
        end
    end

endmodule

// File: rtl/t05_find_least.sv
// Huffman builder front end: scans live leaves and sum nodes over a
// single-outstanding SRAM port and reports the two least-frequent ones.
module t05_find_least #(
    parameter int CHARS   = 256,
    parameter int MAX_SUM = 128,
    parameter int FREQ_W  = 46
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        FLV_en,
    output logic              rd_req,
    output logic              rd_sel,
    output logic [7:0]        rd_addr,
    input  logic [FREQ_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic [8:0]        least1,
    output logic [8:0]        least2,
    output logic [FREQ_W-1:0] sum,
    output logic [6:0]        sum_count,
    output logic [3:0]        op_fin
);
    import t05_flv_pkg::*;

    localparam int CW = (CHARS > 1) ? $clog2(CHARS) : 1;
    localparam int SW = (MAX_SUM > 1) ? $clog2(MAX_SUM) : 1;

    flv_state_t state, state_next, sum_entry;

    logic [7:0]         idx;
    logic [CHARS-1:0]   char_used;
    logic [MAX_SUM-1:0] sum_used;

    logic              pass_en;
    logic              last_char;
    logic              last_sum;
    logic              idx_char_used;
    logic              idx_sum_used;
    logic              count_full;
    logic              found_best;
    logic              found_second;
    logic              lt_clear;
    logic              cand_vld;
    logic [8:0]        cand_node;
    logic [8:0]        best_node;
    logic [8:0]        second_node;
    logic [FREQ_W-1:0] best_freq;
    logic [FREQ_W-1:0] second_freq;

    assign pass_en       = (FLV_en == EN_FLV);
    assign last_char     = (idx == 8'(CHARS - 1));
    assign last_sum      = (idx[6:0] == sum_count - 7'd1);
    assign idx_char_used = char_used[idx[CW-1:0]];
    assign idx_sum_used  = sum_used[idx[SW-1:0]];
    assign count_full    = (sum_count == 7'(MAX_SUM - 1));
    assign found_best    = !is_null(best_node);
    assign found_second  = !is_null(second_node);
    assign sum_entry     = (sum_count == 7'd0) ? S_RESULT : S_SUM_REQ;

    // A returned word is only a candidate while the pass is still enabled;
    // this also discards a late rd_valid after an abort.
    assign lt_clear  = (state == S_IDLE) && pass_en;
    assign cand_vld  = pass_en && rd_valid && (rd_data != '0) &&
                       ((state == S_CHAR_WAIT) || (state == S_SUM_WAIT));
    assign cand_node = (state == S_SUM_WAIT) ? {2'b10, idx[6:0]} : {1'b0, idx};

    t05_least_two #(
        .FREQ_W(FREQ_W)
    ) u_least_two (
        .clk        (clk),
        .rst        (rst),
        .clear      (lt_clear),
        .cand_vld   (cand_vld),
        .cand_node  (cand_node),
        .cand_freq  (rd_data),
        .best_node  (best_node),
        .best_freq  (best_freq),
        .second_node(second_node),
        .second_freq(second_freq)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (pass_en) state_next = S_CHAR_REQ;
            end
            S_CHAR_REQ: begin
                if (!pass_en)          state_next = S_IDLE;
                else if (!idx_char_used) state_next = S_CHAR_WAIT;
                else if (last_char)    state_next = sum_entry;
            end
            S_CHAR_WAIT: begin
                if (!pass_en)          state_next = S_IDLE;
                else if (rd_valid)     state_next = last_char ? sum_entry : S_CHAR_REQ;
            end
            S_SUM_REQ: begin
                if (!pass_en)          state_next = S_IDLE;
                else if (!idx_sum_used) state_next = S_SUM_WAIT;
                else if (last_sum)     state_next = S_RESULT;
            end
            S_SUM_WAIT: begin
                if (!pass_en)          state_next = S_IDLE;
                else if (rd_valid)     state_next = last_sum ? S_RESULT : S_SUM_REQ;
            end
            S_RESULT: begin
                state_next = (found_best && count_full) ? S_ERR : S_DONE;
            end
            S_DONE: begin
                if (!pass_en) state_next = S_IDLE;
            end
            S_ERR: begin
                state_next = S_ERR;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= '0;
            char_used <= '0;
            sum_used  <= '0;
            rd_req    <= 1'b0;
            rd_sel    <= 1'b0;
            rd_addr   <= '0;
            least1    <= NULL_NODE;
            least2    <= NULL_NODE;
            sum       <= '0;
            sum_count <= '0;
            op_fin    <= FIN_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    idx    <= '0;
                    rd_req <= 1'b0;
                    op_fin <= FIN_NONE;
                end
                S_CHAR_REQ: begin
                    if (!pass_en) begin
                        rd_req <= 1'b0;
                    end else if (idx_char_used) begin
                        idx <= last_char ? 8'd0 : idx + 8'd1;
                    end else begin
                        rd_req  <= 1'b1;
                        rd_sel  <= 1'b0;
                        rd_addr <= idx;
                    end
                end
                S_CHAR_WAIT: begin
                    if (!pass_en) begin
                        rd_req <= 1'b0;
                    end else if (rd_valid) begin
                        rd_req <= 1'b0;
                        idx    <= last_char ? 8'd0 : idx + 8'd1;
                    end
                end
                S_SUM_REQ: begin
                    if (!pass_en) begin
                        rd_req <= 1'b0;
                    end else if (idx_sum_used) begin
                        idx <= idx + 8'd1;
                    end else begin
                        rd_req  <= 1'b1;
                        rd_sel  <= 1'b1;
                        rd_addr <= {1'b0, idx[6:0]};
                    end
                end
                S_SUM_WAIT: begin
                    if (!pass_en) begin
                        rd_req <= 1'b0;
                    end else if (rd_valid) begin
                        rd_req <= 1'b0;
                        idx    <= idx + 8'd1;
                    end
                end
                S_RESULT: begin
                    least1 <= best_node;
                    least2 <= second_node;
                    if (found_best && found_second) sum <= best_freq + second_freq;
                    else if (found_best)            sum <= best_freq;
                    else                            sum <= '0;
                    if (is_leaf(best_node))   char_used[best_node[CW-1:0]]   <= 1'b1;
                    if (is_sum(best_node))    sum_used[best_node[SW-1:0]]    <= 1'b1;
                    if (is_leaf(second_node)) char_used[second_node[CW-1:0]] <= 1'b1;
                    if (is_sum(second_node))  sum_used[second_node[SW-1:0]]  <= 1'b1;
                    // The new node would need an index the sum table cannot hold.
                    if (found_best && count_full) begin
                        op_fin <= FIN_ERR;
                    end else begin
                        if (found_best) sum_count <= sum_count + 7'd1;
                        op_fin <= FIN_DONE;
                    end
                end
                S_DONE: begin
                    if (!pass_en) op_fin <= FIN_NONE;
                end
                S_ERR: begin
                    op_fin <= FIN_ERR;
                end
                default: begin
                    rd_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
